// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack ALU opcode interface and its sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stack_alu_pkg;

  // Opcodes understood by the stack ALU.
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  // Operator token codes carried in tok_data[1:0]; codes with bit 1 set are illegal.
  localparam logic [1:0] TOK_ADD = 2'b00;
  localparam logic [1:0] TOK_MUL = 2'b01;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_UNDERFLOW = 2'b01,
    ERR_FULL      = 2'b10,
    ERR_UNBAL     = 2'b11
  } err_code_t;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_ISSUE,
    ST_WAIT,
    ST_POP,
    ST_POPWAIT,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/stack_alu_sequencer.sv
// Sequencer turning an RPN token stream into stack ALU opcodes and a final result.
// Latency: opcode 1 cycle after token acceptance, one token per 3 cycles; result 2 cycles after the last op.
// Backpressure: tok_ready low while an op is in flight or a result is held; result held until res_ready.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   tok_valid/tok_ready           token handshake; tok_op, tok_data, tok_last describe the token
//   alu_opcode, alu_input_data    registered command to the stack ALU
//   alu_output_data, alu_overflow ALU top-of-stack / popped value and overflow flag
//   res_valid/res_ready           result handshake; res_data, res_ovf, res_err, err_code
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_op,
  input  logic [N-1:0] tok_data,
  input  logic         tok_last,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_input_data,
  input  logic [N-1:0] alu_output_data,
  input  logic         alu_overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_ovf,
  output logic         res_err,
  output logic [1:0]   err_code
);

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] TWO       = DW'(2);

  state_t        state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          last_q, last_d;    // tok_last of the most recent accepted token
  logic          arith_q, arith_d;  // issued op was ADD/MUL, so its overflow counts
  logic          ovf_q, ovf_d;      // sticky overflow for the current expression
  err_code_t     err_q, err_d;

  logic [2:0]    opcode_d;
  logic [N-1:0]  in_data_d;
  logic          res_valid_d;
  logic [N-1:0]  res_data_d;
  logic          res_ovf_d;
  logic          res_err_d;

  logic          accept;
  err_code_t     tok_err;
  logic          done_err;

  assign tok_ready = !rst && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign accept    = tok_valid && tok_ready;

  // Classify the presented token against the current stack depth.
  // An illegal operator code is reported as such regardless of depth.
  always_comb begin
    tok_err = ERR_NONE;
    if (!tok_op) begin
      if (depth_q == DEPTH_MAX) tok_err = ERR_FULL;
    end else if (tok_data[1]) begin
      tok_err = ERR_UNBAL;
    end else if (depth_q < TWO) begin
      tok_err = ERR_UNDERFLOW;
    end
  end

  // Error path reaches DONE either straight from FLUSH (erroring token was last)
  // or once the rest of the expression has been drained.
  assign done_err = (state_q == ST_FLUSH && depth_q == '0 && last_q) ||
                    (state_q == ST_DRAIN && accept && tok_last);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (accept) state_d = (tok_err != ERR_NONE) ? ST_FLUSH : ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!last_q)            state_d = ST_RUN;
        else if (depth_q == ONE) state_d = ST_POP;
        else                    state_d = ST_FLUSH;
      end
      ST_POP:     state_d = ST_POPWAIT;
      ST_POPWAIT: state_d = ST_DONE;
      ST_FLUSH: begin
        if (depth_q == '0) state_d = last_q ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (accept && tok_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output / datapath next values. The opcode is computed for the state being
  // entered so that each command sits on the bus for exactly that one cycle.
  always_comb begin
    depth_d     = depth_q;
    last_d      = last_q;
    arith_d     = arith_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    opcode_d    = OP_NOP;
    in_data_d   = alu_input_data;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_ovf_d   = res_ovf;
    res_err_d   = res_err;

    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          last_d = tok_last;
          if (tok_err != ERR_NONE) begin
            err_d = tok_err;
            if (depth_q != '0) opcode_d = OP_POP;
          end else if (!tok_op) begin
            depth_d   = depth_q + ONE;
            opcode_d  = OP_PUSH;
            in_data_d = tok_data;
            arith_d   = 1'b0;
          end else begin
            depth_d  = depth_q - ONE;
            opcode_d = (tok_data[1:0] == TOK_MUL) ? OP_MUL : OP_ADD;
            arith_d  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (arith_q) ovf_d = ovf_q | alu_overflow;
        if (last_q) begin
          if (depth_q == ONE) begin
            opcode_d = OP_POP;
          end else begin
            err_d = ERR_UNBAL;
            if (depth_q != '0) opcode_d = OP_POP;
          end
        end
      end
      ST_POP: depth_d = '0;
      ST_POPWAIT: begin
        res_valid_d = 1'b1;
        res_data_d  = alu_output_data;
        res_ovf_d   = ovf_q;
        res_err_d   = 1'b0;
      end
      ST_FLUSH: begin
        if (depth_q != '0) begin
          depth_d = depth_q - ONE;
          if (depth_q > ONE) opcode_d = OP_POP;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_ovf_d   = 1'b0;
          res_err_d   = 1'b0;
          ovf_d       = 1'b0;
          err_d       = ERR_NONE;
        end
      end
      default: ;
    endcase

    if (done_err) begin
      res_valid_d = 1'b1;
      res_err_d   = 1'b1;
      res_data_d  = '0;
      res_ovf_d   = ovf_q;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q        <= '0;
      last_q         <= 1'b0;
      arith_q        <= 1'b0;
      ovf_q          <= 1'b0;
      err_q          <= ERR_NONE;
      alu_opcode     <= OP_NOP;
      alu_input_data <= '0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_ovf        <= 1'b0;
      res_err        <= 1'b0;
    end else begin
      depth_q        <= depth_d;
      last_q         <= last_d;
      arith_q        <= arith_d;
      ovf_q          <= ovf_d;
      err_q          <= err_d;
      alu_opcode     <= opcode_d;
      alu_input_data <= in_data_d;
      res_valid      <= res_valid_d;
      res_data       <= res_data_d;
      res_ovf        <= res_ovf_d;
      res_err        <= res_err_d;
    end
  end

  assign err_code = err_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Randomised and directed bench for stack_alu_sequencer with a behavioural stack ALU.
// Latency: n/a.
// Backpressure: res_ready is randomised, with a forced stall window.
module tb_stack_alu_sequencer;
  import stack_alu_pkg::*;

  localparam int N     = 32;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         tok_valid, tok_ready, tok_op, tok_last;
  logic [N-1:0] tok_data;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_input_data;
  logic [N-1:0] alu_out;
  logic         alu_ovf;
  logic         res_valid, res_ready, res_ovf, res_err;
  logic [N-1:0] res_data;
  logic [1:0]   err_code;

  always #5 clk = ~clk;

  stack_alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_op(tok_op),
    .tok_data(tok_data), .tok_last(tok_last),
    .alu_opcode(alu_opcode), .alu_input_data(alu_input_data),
    .alu_output_data(alu_out), .alu_overflow(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .res_err(res_err), .err_code(err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit add_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic bit mul_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  // ---------------- behavioural stack ALU ----------------
  logic [N-1:0] alu_mem [16];
  int           alu_sp;
  int           alu_bad = 0;
  logic [N-1:0] alu_a, alu_b, alu_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_sp = 0;
      alu_out <= '0;
      alu_ovf <= 1'b0;
    end else begin
      case (alu_opcode)
        OP_PUSH: begin
          if (alu_sp < 16) begin alu_mem[alu_sp] = alu_input_data; alu_sp = alu_sp + 1; end
          else alu_bad++;
          alu_out <= alu_input_data;
        end
        OP_ADD, OP_MUL: begin
          if (alu_sp >= 2) begin
            alu_a = alu_mem[alu_sp-1];
            alu_b = alu_mem[alu_sp-2];
            alu_sp = alu_sp - 1;
            alu_r = (alu_opcode == OP_ADD) ? alu_a + alu_b : alu_a * alu_b;
            alu_mem[alu_sp-1] = alu_r;
            alu_out <= alu_r;
            alu_ovf <= (alu_opcode == OP_ADD) ? add_ovf(alu_a, alu_b) : mul_ovf(alu_a, alu_b);
          end else alu_bad++;
        end
        OP_POP: begin
          if (alu_sp > 0) begin alu_sp = alu_sp - 1; alu_out <= alu_mem[alu_sp]; end
          else alu_bad++;
        end
        OP_NOP: ;
        default: alu_bad++;
      endcase
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [N-1:0] data;
    bit           ovf;
    bit           err;
    logic [1:0]   code;
    int           ops;
  } exp_t;

  bit           t_op[$];
  logic [N-1:0] t_dat[$];
  exp_t         exp_q[$];

  // Evaluates the expression in t_op/t_dat the way a careful human would:
  // a value stack, error on the first bad token, then count the ALU commands.
  function automatic exp_t ref_eval();
    logic [N-1:0] st[$];
    logic [N-1:0] a, b;
    exp_t e;
    e.data = '0; e.ovf = 0; e.err = 0; e.code = 2'b00; e.ops = 0;
    for (int i = 0; i < t_op.size(); i++) begin
      if (!t_op[i]) begin
        if (st.size() == DEPTH) begin e.err = 1; e.code = 2'b10; end
        else begin st.push_back(t_dat[i]); e.ops++; end
      end else if (t_dat[i][1]) begin
        e.err = 1; e.code = 2'b11;
      end else if (st.size() < 2) begin
        e.err = 1; e.code = 2'b01;
      end else begin
        a = st.pop_back();
        b = st.pop_back();
        if (!t_dat[i][0]) begin st.push_back(a + b); e.ovf |= add_ovf(a, b); end
        else              begin st.push_back(a * b); e.ovf |= mul_ovf(a, b); end
        e.ops++;
      end
      if (e.err) break;
      if (i == t_op.size() - 1 && st.size() != 1) begin e.err = 1; e.code = 2'b11; end
    end
    if (e.err) begin e.ops += st.size(); e.data = '0; end
    else begin e.ops++; e.data = st[0]; end
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  bit force_stall = 0;
  bit gaps        = 0;

  always @(posedge clk) begin
    #1;
    res_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic send_tok(input bit op, input logic [N-1:0] d, input bit last);
    int n;
    tok_valid = 1'b1; tok_op = op; tok_data = d; tok_last = last;
    n = 0;
    while (!tok_ready && n < 300) begin @(negedge clk); n++; end
    if (!tok_ready) begin
      n_checks++; n_fail++;
      $display("FAIL tok_accept_timeout: tok_ready=%0d after %0d cycles, required 1", tok_ready, n);
    end else @(negedge clk);
    tok_valid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic clr_expr();
    t_op.delete(); t_dat.delete();
  endtask

  task automatic add_tok(input bit op, input logic [N-1:0] d);
    t_op.push_back(op); t_dat.push_back(d);
  endtask

  task automatic send_expr();
    exp_q.push_back(ref_eval());
    for (int i = 0; i < t_op.size(); i++) send_tok(t_op[i], t_dat[i], i == t_op.size() - 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL result_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic gen_random();
    int len, d;
    logic [N-1:0] v;
    clr_expr();
    len = $urandom_range(1, 12);
    d = 0;
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(0, 9) < 5 || (d == 0 && $urandom_range(0, 3) != 0)) begin
        v = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 100));
        add_tok(1'b0, v);
        d++;
      end else begin
        v = N'($urandom);
        v[1] = (d >= 2 && $urandom_range(0, 15) == 0);
        v[0] = 1'($urandom_range(0, 1));
        add_tok(1'b1, v);
        if (d >= 2) d--;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int           op_cnt = 0;
  bit           stall_prev = 0;
  logic [N-1:0] p_data;
  logic [3:0]   p_flags;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (rst) begin
      op_cnt = 0;
      stall_prev = 0;
    end else begin
      if (alu_opcode != OP_NOP) op_cnt++;
      if (res_valid) begin
        chk("tok_ready_while_result", tok_ready, 0);
        if (stall_prev) begin
          chk("hold_res_data", res_data, p_data);
          chk("hold_res_flags", {res_ovf, res_err, err_code}, p_flags);
        end
        if (res_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_result: data=%0h err=%0d, required no result", res_data, res_err);
          end else begin
            mon_e = exp_q.pop_front();
            chk("res_data", res_data, mon_e.data);
            chk("res_err", res_err, mon_e.err);
            chk("err_code", err_code, mon_e.code);
            if (!mon_e.err) chk("res_ovf", res_ovf, mon_e.ovf);
            chk("alu_op_cycles", op_cnt, mon_e.ops);
            chk("alu_stack_empty", alu_sp, 0);
            chk("alu_misuse", alu_bad, 0);
          end
          op_cnt = 0;
        end
        stall_prev = !res_ready;
        p_data = res_data;
        p_flags = {res_ovf, res_err, err_code};
      end else stall_prev = 0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; tok_valid = 1'b0; tok_op = 1'b0; tok_data = '0; tok_last = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tok_ready", tok_ready, 0);
    chk("rst_alu_opcode", alu_opcode, OP_NOP);
    chk("rst_alu_input", alu_input_data, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_flags", {res_data, res_ovf, res_err, err_code}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("run_tok_ready", tok_ready, 1);

    // 10 20 +
    clr_expr(); add_tok(0, 10); add_tok(0, 20); add_tok(1, 0); send_expr();
    // 3 4 + 5 *
    clr_expr(); add_tok(0, 3); add_tok(0, 4); add_tok(1, 0); add_tok(0, 5); add_tok(1, 1); send_expr();
    // overflow, then the flag must not leak into the next expression
    clr_expr(); add_tok(0, 32'h7FFF_FFFF); add_tok(0, 1); add_tok(1, 0); send_expr();
    clr_expr(); add_tok(0, 2); add_tok(0, 2); add_tok(1, 1); send_expr();
    // underflow with drained tail
    clr_expr(); add_tok(0, 5); add_tok(1, 0); add_tok(0, 7); add_tok(0, 8); send_expr();
    // unbalanced, then recovery
    clr_expr(); add_tok(0, 1); add_tok(0, 2); send_expr();
    clr_expr(); add_tok(0, 6); add_tok(0, 7); add_tok(1, 1); send_expr();
    // stack full
    clr_expr(); for (int i = 0; i <= DEPTH; i++) add_tok(0, N'(i + 1)); send_expr();
    // illegal operator code with enough operands
    clr_expr(); add_tok(0, 1); add_tok(0, 2); add_tok(1, 32'h0000_0002); add_tok(0, 9); send_expr();
    wait_idle();

    // result held under backpressure
    force_stall = 1;
    clr_expr(); add_tok(0, 6); add_tok(0, 7); add_tok(1, 1); send_expr();
    begin
      int n;
      n = 0;
      while (!res_valid && n < 100) begin @(negedge clk); n++; end
      chk("stall_result_seen", res_valid, 1);
      repeat (5) begin
        @(negedge clk);
        chk("stall_res_valid", res_valid, 1);
        chk("stall_tok_ready", tok_ready, 0);
      end
    end
    force_stall = 0;
    wait_idle();

    // asynchronous reset while a PUSH is on the bus
    tok_valid = 1'b1; tok_op = 1'b0; tok_data = 32'd9; tok_last = 1'b0;
    chk("pre_reset_ready", tok_ready, 1);
    @(posedge clk); #1;
    chk("issue_opcode", alu_opcode, OP_PUSH);
    rst = 1'b1;
    #1;
    chk("async_rst_opcode", alu_opcode, OP_NOP);
    chk("async_rst_res_valid", res_valid, 0);
    chk("async_rst_tok_ready", tok_ready, 0);
    tok_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tok_ready", tok_ready, 1);
    chk("post_rst_err_code", err_code, 0);

    // randomised expressions
    gaps = 1;
    for (int k = 0; k < 40; k++) begin
      gen_random();
      send_expr();
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_alu_sequencer.md
Name: stack_alu_sequencer

Overview:
- Initiator for the STACK_BASED_ALU opcode interface.
- Accepts a postfix (RPN) expression as a valid/ready token stream and issues PUSH/ADD/MUL/POP opcodes and operands to the stack ALU, one operation at a time.
- Tracks ALU stack depth, accumulates overflow, pops and returns the final result. Reports malformed expressions and leaves the ALU stack empty after every expression.

Parameters:
- N, 32, operand/result width; must match the ALU's n.
- DEPTH, 8, ALU stack capacity in entries.
- DW, $clog2(DEPTH+1), width of the internal depth counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tok_valid  in  1  token present.
- tok_ready  out  1  sequencer accepts the token this cycle.
- tok_op  in  1  1 = operator token, 0 = operand token.
- tok_data  in  N  operand value. For operators, bits [1:0] give the operator: 00 ADD, 01 MUL, others illegal.
- tok_last  in  1  final token of the expression.
- alu_opcode  out  3  opcode to the ALU (registered).
- alu_input_data  out  N  operand to the ALU (registered).
- alu_output_data  in  N  ALU result/top of stack.
- alu_overflow  in  1  ALU overflow flag.
- res_valid  out  1  result/status available.
- res_ready  in  1  consumer takes the result.
- res_data  out  N  final value (0 on error).
- res_ovf  out  1  any ADD/MUL in the expression overflowed.
- res_err  out  1  expression malformed.
- err_code  out  2  00 none, 01 underflow, 10 stack full, 11 unbalanced/illegal op.

Behaviour:
- Reset values:
  - State RUN; depth=0.
  - alu_opcode=NOP(000); alu_input_data=0.
  - tok_ready=0 during reset; after reset it is 1 in RUN.
  - res_valid=0, res_data=0, res_ovf=0, res_err=0, err_code=00.
- Reset mid-expression aborts immediately. The ALU stack is not flushed by reset; the system resets both blocks together.
- alu_opcode is NOP in every cycle not listed below. Each non-NOP opcode is held for exactly one cycle.
- RUN: tok_ready=1. On tok_valid&tok_ready:
  - Operand with depth<DEPTH: register PUSH and tok_data, depth+1, go to ISSUE.
  - Operand with depth==DEPTH: error 10.
  - Operator 00/01 with depth>=2: register ADD/MUL, depth-1, go to ISSUE.
  - Operator with depth<2: error 01.
  - Operator code 1x: error 11.
  - On any error no opcode is issued; go to FLUSH.
  - Latch tok_last with the token.
- ISSUE: opcode is on the bus for this one cycle; tok_ready=0. Go to WAIT.
- WAIT: tok_ready=0.
  - If the issued op was ADD/MUL, OR alu_overflow into sticky ovf.
  - If the latched last is 0, go to RUN.
  - If last=1 and depth==1, go to POP.
  - If last=1 and depth!=1, error 11 and go to FLUSH.
- Timing: one token per 3 cycles; the opcode appears 1 cycle after token acceptance.
- POP: drive POP for 1 cycle, depth=0. Go to POPWAIT.
- POPWAIT: capture alu_output_data into res_data, capture ovf into res_ovf, set res_valid=1. Go to DONE.
- FLUSH: drive one POP per cycle while depth>0, decrementing each cycle. When depth==0:
  - Go to DRAIN if the erroring token was not last.
  - Otherwise go to DONE with res_valid=1, res_err=1, res_data=0.
- DRAIN: tok_ready=1; accepted tokens are discarded until one with tok_last=1. Then go to DONE with the error result.
- DONE: outputs are held stable while res_valid & !res_ready. On res_ready:
  - res_valid=0.
  - Clear ovf, res_err and err_code.
  - Go to RUN. The next token may be accepted in the following cycle.
- Width rules: results are N bits, truncated as the ALU produces them; no sign extension. Depth never exceeds DEPTH and never goes below 0.

Decomposition:
- Shared package stack_alu_pkg:
  - Opcode constants OP_NOP=000, OP_ADD=100, OP_MUL=101, OP_PUSH=110, OP_POP=111.
  - Operator token codes.
  - err_code enum.
  - State enum {RUN, ISSUE, WAIT, POP, POPWAIT, FLUSH, DRAIN, DONE}.
- No sub-module. Single FSM plus depth counter; the ALU is instantiated only in the bench/top.

Test Plan:
- Tokens 10, 20, + (last) -> opcodes PUSH10, PUSH20, ADD, POP in order. res_data=30, res_ovf=0, res_err=0.
- Tokens 3, 4, +, 5, * (last) -> res_data=35. Exactly 5 non-NOP ops plus 1 POP; each op lasts one cycle.
- Tokens 0x7FFFFFFF, 1, + (last) -> res_data=0x80000000, res_ovf=1. Following expression 2, 2, * -> res_data=4, res_ovf=0 (ovf cleared).
- Tokens 5, + (not last), 7, 8 (last) -> err_code=01. One FLUSH POP. Tokens 7 and 8 are drained with no opcodes issued. res_err=1, res_data=0.
- Tokens 1, 2 (last) -> err_code=11, two FLUSH POPs, depth=0. The next expression 6, 7, * returns 42. Also: DEPTH+1 operands -> err_code=10 and DEPTH flush POPs.
- res_ready held low 5 cycles -> res_* stable and tok_ready=0. Assert rst during ISSUE -> alu_opcode=NOP and res_valid=0 immediately (asynchronously).
